// File: rtl/beamform_pkg.sv
// Shared beamforming defaults, the delay-and-sum sequencer state type and the
// channel-buffer base-address helper.
package beamform_pkg;

  localparam int NUM_CH_DEF   = 8;
  localparam int NUM_SAMP_DEF = 768;
  localparam int DATA_W_DEF   = 32;
  localparam int SUM_W_DEF    = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dsum_state_e;

  // Channel c occupies a contiguous block of num_samp words in the channel buffer.
  function automatic int unsigned chan_base(input int unsigned ch,
                                            input int unsigned num_samp = NUM_SAMP_DEF);
    return ch * num_samp;
  endfunction

endpackage

// File: rtl/dsum_rd_pipe.sv
// Fixed-latency tag pipe: carries {valid, first ch, last ch, t} alongside each channel-buffer read.
// Latency RD_LAT cycles; advances every cycle with no backpressure, flushed by reset_n.
module dsum_rd_pipe
  import beamform_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int T_W    = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_vld,
  input  logic           in_first,
  input  logic           in_last,
  input  logic [T_W-1:0] in_t,
  output logic           out_vld,
  output logic           out_first,
  output logic           out_last,
  output logic [T_W-1:0] out_t,
  output logic           empty
);

  typedef struct packed {
    logic           vld;
    logic           is_first;
    logic           is_last;
    logic [T_W-1:0] t;
  } tag_t;

  tag_t pipe_q [RD_LAT];
  tag_t pipe_d [RD_LAT];

  always_comb begin
    pipe_d[0] = '{vld: in_vld, is_first: in_first, is_last: in_last, t: in_t};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_q[i].vld) empty = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_vld   = pipe_q[RD_LAT-1].vld;
  assign out_first = pipe_q[RD_LAT-1].is_first;
  assign out_last  = pipe_q[RD_LAT-1].is_last;
  assign out_t     = pipe_q[RD_LAT-1].t;

endmodule

// File: rtl/delay_sum_sequencer.sv
// Delay-and-sum sequencer: streams t-major channel reads, accumulates NUM_CH beats per sample, writes sum RAM.
// Sum for t appears RD_LAT+1 cycles after its last-channel read is accepted; rd_gnt gaps stall issue only.
// Build option DSUM_AVG_EN writes the channel mean (acc >>> log2(NUM_CH)) instead of the raw sum.
module delay_sum_sequencer
  import beamform_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int NUM_SAMP   = NUM_SAMP_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SUM_W      = SUM_W_DEF,
  parameter int RD_ADDR_W  = 13,
  parameter int SUM_ADDR_W = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  input  logic                  rd_gnt,
  output logic [RD_ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  sum_we,
  output logic [SUM_ADDR_W-1:0] sum_addr,
  output logic [SUM_W-1:0]      sum_data
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int T_W  = SUM_ADDR_W;

  dsum_state_e           state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [T_W-1:0]        t_q, t_d;
  logic                  rd_en_q, rd_en_d;
  logic [RD_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [SUM_W-1:0]      acc_q, acc_d;
  logic                  sum_we_q, sum_we_d;
  logic [SUM_ADDR_W-1:0] sum_addr_q, sum_addr_d;
  logic [SUM_W-1:0]      sum_data_q, sum_data_d;

  logic           accept, ch_last, last_rd;
  logic           p_vld, p_first, p_last, pipe_empty;
  logic [T_W-1:0] p_t;
  logic [SUM_W-1:0] data_sx;

  assign accept  = rd_en_q && rd_gnt;
  assign ch_last = (ch_q == CH_W'(NUM_CH - 1));
  assign last_rd = ch_last && (t_q == T_W'(NUM_SAMP - 1));
  assign data_sx = {{(SUM_W - DATA_W){rd_data[DATA_W-1]}}, rd_data};

  dsum_rd_pipe #(
    .RD_LAT (RD_LAT),
    .T_W    (T_W)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_vld    (accept),
    .in_first  (ch_q == '0),
    .in_last   (ch_last),
    .in_t      (t_q),
    .out_vld   (p_vld),
    .out_first (p_first),
    .out_last  (p_last),
    .out_t     (p_t),
    .empty     (pipe_empty)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    t_d       = t_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          ch_d      = '0;
          t_d       = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (last_rd) begin
            state_d = DRAIN;
            rd_en_d = 1'b0;
          end else begin
            ch_d      = ch_q + CH_W'(1);
            t_d       = ch_last ? t_q + T_W'(1) : t_q;
            rd_addr_d = RD_ADDR_W'(chan_base(32'(ch_d), 32'(NUM_SAMP)) + 32'(t_d));
          end
        end
      end
      // Wait one extra cycle past the final write so done strictly follows it.
      DRAIN:   if (pipe_empty && !sum_we_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    sum_we_d   = 1'b0;
    sum_addr_d = sum_addr_q;
    sum_data_d = sum_data_q;
    if (p_vld) begin
      acc_d = p_first ? data_sx : acc_q + data_sx;
      if (p_last) begin
        sum_we_d   = 1'b1;
        sum_addr_d = p_t;
`ifdef DSUM_AVG_EN
        sum_data_d = $signed(acc_d) >>> CH_W;
`else
        sum_data_d = acc_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      t_q        <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      acc_q      <= '0;
      sum_we_q   <= 1'b0;
      sum_addr_q <= '0;
      sum_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      t_q        <= t_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      acc_q      <= acc_d;
      sum_we_q   <= sum_we_d;
      sum_addr_q <= sum_addr_d;
      sum_data_q <= sum_data_d;
    end
  end

  assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign sum_we   = sum_we_q;
  assign sum_addr = sum_addr_q;
  assign sum_data = sum_data_q;

endmodule

// File: tb/tb_delay_sum_sequencer.sv
// Bench for delay_sum_sequencer: behavioural channel-buffer RAM (latency 2) plus a per-sample sum model.
module tb_delay_sum_sequencer;

  localparam int NUM_CH   = 8;
  localparam int NUM_SAMP = 768;
  localparam int NWORDS   = NUM_CH * NUM_SAMP;
  localparam int MIN_PASS = NWORDS + 2 + 3;
  localparam int BUDGET   = 20000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, rd_en, sum_we;
  logic        rd_gnt;
  logic [12:0] rd_addr;
  logic [31:0] rd_data;
  logic [9:0]  sum_addr;
  logic [39:0] sum_data;

  always #5 clk = ~clk;

  delay_sum_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_gnt   (rd_gnt),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .sum_we   (sum_we),
    .sum_addr (sum_addr),
    .sum_data (sum_data)
  );

  logic [31:0] mem [NWORDS];
  logic [31:0] rd_stage1;

  // Two-cycle read RAM; non-accepted slots return junk so stray accumulation is visible.
  always @(posedge clk) begin
    rd_stage1 <= (rd_en && rd_gnt) ? mem[rd_addr] : $urandom;
    rd_data   <= rd_stage1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] model_sum(input int t);
    longint s = 0;
    for (int c = 0; c < NUM_CH; c++) s += longint'($signed(mem[c*NUM_SAMP + t]));
`ifdef DSUM_AVG_EN
    s = s >>> 3;
`endif
    return s[39:0];
  endfunction

  task automatic fill_mem(input int mode);
    for (int a = 0; a < NWORDS; a++) begin
      case (mode)
        0:       mem[a] = 32'((a / NUM_SAMP) * 1000 + (a % NUM_SAMP));
        1:       mem[a] = 32'hFFFF_FFFF;
        default: mem[a] = $urandom;
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_rd_en"},    rd_en,    0);
    check({tag, "_sum_we"},   sum_we,   0);
    check({tag, "_rd_addr"},  rd_addr,  0);
    check({tag, "_sum_addr"}, sum_addr, 0);
    check({tag, "_sum_data"}, sum_data, 0);
  endtask

  task automatic run_pass(input int gnt_pct, input bit repulse, input bit has_const,
                          input logic [39:0] exp_first, input logic [39:0] exp_last,
                          input bit exact_len);
    int nwr = 0, ndone = 0, done_cyc = 0, viol = 0, hold_bad = 0, tail = 0;
    logic prev_en = 1'b0, prev_gnt = 1'b0;
    logic [12:0] prev_addr = '0;
    @(negedge clk);
    start  = 1'b1;
    rd_gnt = ($urandom_range(99) < gnt_pct);
    @(posedge clk);
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (prev_en && !prev_gnt && (!rd_en || rd_addr !== prev_addr)) hold_bad++;
      if ((rd_en || sum_we) && !busy) viol++;
      if (ndone > 0 && !done && busy) viol++;
      if (sum_we) begin
        if (nwr < NUM_SAMP) begin
          check("sum_addr", sum_addr, nwr);
          check("sum_data", sum_data, model_sum(nwr));
          if (has_const && nwr == 0) check("first_sum", sum_data, exp_first);
          if (has_const && nwr == NUM_SAMP - 1) check("last_sum", sum_data, exp_last);
        end
        nwr++;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = cyc;
          check("busy_at_done", busy, 0);
          check("writes_before_done", nwr, NUM_SAMP);
        end
        if (repulse) start = 1'b1;
      end
      if (repulse && cyc == 100) start = 1'b1;
      rd_gnt    = ($urandom_range(99) < gnt_pct);
      prev_en   = rd_en;
      prev_gnt  = rd_gnt;
      prev_addr = rd_addr;
      if (ndone > 0) tail++;
      if (tail >= 12) break;
    end
    start = 1'b0;
    check("write_count", nwr, NUM_SAMP);
    check("done_pulses", ndone, 1);
    check("protocol_violations", viol, 0);
    check("addr_hold_violations", hold_bad, 0);
    if (exact_len) check("pass_len", done_cyc, MIN_PASS);
    else           check("pass_len_stalled", (done_cyc > MIN_PASS), 1);
  endtask

  typedef struct {
    int          mode;
    int          gnt_pct;
    bit          repulse;
    bit          has_const;
    logic [39:0] exp_first;
    logic [39:0] exp_last;
    bit          exact_len;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [39:0] inc_first, inc_last, neg_all;
    int act;
`ifdef DSUM_AVG_EN
    inc_first = 40'd3500;
    inc_last  = 40'd4267;
    neg_all   = 40'hFF_FFFF_FFFF;
`else
    inc_first = 40'd28000;
    inc_last  = 40'd34136;
    neg_all   = 40'hFF_FFFF_FFF8;
`endif
    vecs[0] = '{0, 100, 1'b0, 1'b1, inc_first, inc_last, 1'b1};
    vecs[1] = '{1, 100, 1'b1, 1'b1, neg_all,   neg_all,  1'b1};
    vecs[2] = '{0, 50,  1'b0, 1'b1, inc_first, inc_last, 1'b0};
    vecs[3] = '{2, 70,  1'b0, 1'b0, 40'd0,     40'd0,    1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    rd_gnt  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      fill_mem(vecs[i].mode);
      run_pass(vecs[i].gnt_pct, vecs[i].repulse, vecs[i].has_const,
               vecs[i].exp_first, vecs[i].exp_last, vecs[i].exact_len);
    end

    // Abort mid-pass: reset must clear outputs immediately and leave the block idle.
    fill_mem(0);
    @(negedge clk);
    start  = 1'b1;
    rd_gnt = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (sum_we || done || busy || rd_en) act++;
    end
    check("activity_after_abort", act, 0);
    run_pass(100, 1'b0, 1'b1, inc_first, inc_last, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_sum_sequencer.md
Name: delay_sum_sequencer

Overview:
Sequences the delay-and-sum stage of the beamforming pipeline. On `start`, it streams the delayed channel samples out of the output (channel-buffer) RAM one read per granted cycle. For each sample index it accumulates the NUM_CH channel values and writes the result into the sum RAM. It replaces hand-stepped summing states with a pipelined, latency-aware engine that shares the channel-buffer read port through a request/grant handshake.

Parameters:
- NUM_CH, 8: channels summed per output sample; must be a power of 2 and at least 2.
- NUM_SAMP, 768: samples per channel; channel c occupies rd_addr c*NUM_SAMP .. c*NUM_SAMP+NUM_SAMP-1.
- DATA_W, 32: channel sample width, two's complement.
- SUM_W, 40: accumulator and sum_data width; must be at least DATA_W+log2(NUM_CH).
- RD_ADDR_W, 13: channel-buffer address width.
- SUM_ADDR_W, 10: sum RAM address width.
- RD_LAT, 2: channel-buffer read latency in cycles; range 1..4.

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to run a full pass; sampled only in IDLE.
- busy, out, 1: high from the cycle after start is accepted until done.
- done, out, 1: one-cycle pulse after the final sum write.
- rd_en, out, 1: read request to the channel-buffer arbiter.
- rd_gnt, in, 1: read accepted in the same cycle when rd_en && rd_gnt.
- rd_addr, out, RD_ADDR_W: read address, held stable while rd_en && !rd_gnt.
- rd_data, in, DATA_W: valid RD_LAT cycles after an accepted read.
- sum_we, out, 1: sum RAM write strobe, one cycle.
- sum_addr, out, SUM_ADDR_W: sample index t.
- sum_data, out, SUM_W: sum for sample t.

Behaviour:
- Reset: state goes to IDLE. busy, done, rd_en, sum_we are 0. rd_addr, sum_addr, sum_data, accumulator, counters and the valid pipe are all 0.
- States:
  - IDLE: on start go to ISSUE. Clear t=0, ch=0.
  - ISSUE: hold rd_en=1 and rd_addr = ch*NUM_SAMP + t, registered. On acceptance, ch increments; when ch wraps from NUM_CH-1 to 0, t increments. Acceptance of (ch=NUM_CH-1, t=NUM_SAMP-1) goes to DRAIN, and rd_en drops on the next cycle.
  - DRAIN: wait until the valid pipe is empty and the last sum_we has issued, then go to DONE.
  - DONE: done=1 for one cycle, busy=0 from the same cycle, return to IDLE.
- Read order is t-major: t0c0, t0c1, …, t0c7, t1c0, and so on.
- Valid pipe: an RD_LAT-deep shift register carries {valid, ch==0, ch==NUM_CH-1, t} per accepted read. It advances every cycle regardless of rd_gnt, because RAM latency is fixed.
- Accumulate on a returning valid beat:
  - first channel: acc = sext(rd_data);
  - otherwise: acc = acc + sext(rd_data);
  - sign-extend from DATA_W to SUM_W; no overflow is possible given the SUM_W rule.
- Write: on the beat for the last channel, the next cycle drives sum_we=1, sum_addr=t and sum_data = final acc, all registered.
- Latency: the sum for t appears RD_LAT+1 cycles after the read for channel NUM_CH-1 of t is accepted.
- Minimum pass length with rd_gnt tied high: NUM_CH*NUM_SAMP + RD_LAT + 3 cycles from start to done. With the defaults and RD_LAT=2 that is 6149 cycles.
- Grant gaps stall issue only. In-flight beats still complete, and the accumulator holds across bubbles.
- start while busy is ignored.
- start in the same cycle as DONE is ignored; it is accepted only in IDLE.
- Reset mid-pass aborts immediately. No further sum_we, no done pulse. Partial sum RAM contents are left as written.
- sum_we is never asserted outside ISSUE/DRAIN.
- rd_en is never asserted outside ISSUE.

Optional Feature:
- Macro DSUM_AVG_EN.
  - Defined: sum_data = acc >>> log2(NUM_CH), an arithmetic shift that keeps the sign at SUM_W, giving the channel mean. Write timing is unchanged.
  - Undefined: sum_data = raw acc.

Decomposition:
- Shared package beamform_pkg holds:
  - defaults NUM_CH, NUM_SAMP, DATA_W, SUM_W;
  - the state enum {IDLE, ISSUE, DRAIN, DONE};
  - a function chan_base(ch) returning ch*NUM_SAMP.
- One natural sub-module: dsum_rd_pipe, the RD_LAT-deep valid/tag shift register with flush on reset_n.
- Accumulator and FSM stay in the top module.

Test Plan:
- rd_gnt tied 1, RD_LAT=2, channel c sample t = c*1000+t: sum_data(t) = 28000+8t, 768 writes with sum_addr 0..767 in order, and done at cycle 6149 after start.
- Same data with DSUM_AVG_EN: sum_data(t) = (28000+8t)>>>3 = 3500+t.
- Negative data, all samples = 32'hFFFF_FFFF (−1): every sum_data = 40'hFF_FFFF_FFF8 (−8), proving sign extension.
- rd_gnt random at 50% duty: rd_addr is held while ungranted, sums are identical to the first test, and done is delayed but present exactly once.
- start pulsed again mid-pass and in the DONE cycle: ignored, single done, 768 writes total.
- reset_n asserted at t=300 mid-pass: all outputs 0 asynchronously, no done, no sum_we after release. A fresh start then completes a full pass correctly.
